// File: rtl/gf180mcu_fd_sc_mcu9t5v0_crc8_ser_pkg.sv
// Shared definitions for the serial CRC accumulator: FSM encoding, default
// generator/seed constants and the supported register width range.
package gf180mcu_fd_sc_mcu9t5v0_crc8_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIN  = 2'b10
  } crc_state_e;

  // Stored 16 bits wide so any legal WIDTH can slice its default from them.
  localparam logic [15:0] DEFAULT_POLY = 16'h0007;
  localparam logic [15:0] DEFAULT_INIT = 16'h0000;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 16;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_crc8_ser_crc_step.sv
// Single-bit CRC feedback stage: shift left one place and fold in POLY when
// the incoming bit disagrees with the register MSB. Purely combinational.
module gf180mcu_fd_sc_mcu9t5v0_crc_step #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = 8'h07
) (
  input  logic [WIDTH-1:0] crc_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] crc_o
);

  logic fb;

  assign fb    = d_i ^ crc_i[WIDTH-1];
  assign crc_o = {crc_i[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_crc8_ser.sv
// Serial MSB-first CRC accumulator with frame FSM, DONE strobe and ZERO flag.
// Define GF180MCU_FD_SC_MCU9T5V0_CRC_XOROUT_EN to invert the presented CRC.
module gf180mcu_fd_sc_mcu9t5v0_crc8_ser
  import gf180mcu_fd_sc_mcu9t5v0_crc8_ser_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0] INIT  = DEFAULT_INIT[WIDTH-1:0]
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  input  logic             last_i,
  output logic [WIDTH-1:0] q_o,
  output logic             done_o,
  output logic             zero_o
);

  crc_state_e       state_q;
  logic [WIDTH-1:0] crc_q;
  logic             done_q;
  logic [WIDTH-1:0] crc_seed;
  logic [WIDTH-1:0] crc_d;

  // Only a frame already in progress continues from the register; IDLE and
  // FIN start a fresh frame from INIT, which allows back-to-back frames.
  assign crc_seed = (state_q == BUSY) ? crc_q : INIT;

  gf180mcu_fd_sc_mcu9t5v0_crc_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_i (crc_seed),
    .d_i   (d_i),
    .crc_o (crc_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      done_q  <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          if (en_i) begin
            crc_q   <= crc_d;
            state_q <= last_i ? FIN : BUSY;
            done_q  <= last_i;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (en_i) begin
            crc_q <= crc_d;
            if (last_i) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ZERO always looks at the raw register so residue checks ignore XOROUT.
  assign zero_o = (crc_q == {WIDTH{1'b0}});
  assign done_o = done_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0_CRC_XOROUT_EN
  assign q_o = crc_q ^ {WIDTH{1'b1}};
`else
  assign q_o = crc_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_crc8_ser.sv
// Directed self-checking bench for the serial CRC-8 accumulator (POLY 07, INIT 00).
// Expected CRCs are hand-computed; XOROUT build expectations follow the macro.
module tb_gf180mcu_fd_sc_mcu9t5v0_crc8_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       d = 1'b0;
  logic       last = 1'b0;
  logic [7:0] q;
  logic       done;
  logic       zero;

  int nChecks = 0;
  int nFail = 0;

  gf180mcu_fd_sc_mcu9t5v0_crc8_ser dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .en_i   (en),
    .d_i    (d),
    .last_i (last),
    .q_o    (q),
    .done_o (done),
    .zero_o (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expQ(input logic [7:0] raw);
`ifdef GF180MCU_FD_SC_MCU9T5V0_CRC_XOROUT_EN
    return raw ^ 8'hFF;
`else
    return raw;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted bit: drive after the edge, let the next edge absorb it, sample 1 ns later.
  task automatic applyStimulus(input logic bitVal, input logic lastVal);
    en = 1'b1;
    d = bitVal;
    last = lastVal;
    @(posedge clk);
    #1;
    en = 1'b0;
    d = 1'b0;
    last = 1'b0;
  endtask

  task automatic sendBits(input logic [15:0] value, input int nbits, input logic lastOnFinal);
    for (int i = nbits - 1; i >= 0; i--) begin
      applyStimulus(value[i], lastOnFinal && (i == 0));
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [71:0] digits;
    digits = 72'h31_32_33_34_35_36_37_38_39;

    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    idleCycle();
    checkOutput("reset_q", 16'(q), 16'(expQ(8'h00)));
    checkOutput("reset_done", 16'(done), 16'h0);
    checkOutput("reset_zero", 16'(zero), 16'h1);

    // Async reset mid-frame after three bits of 1.
    sendBits(16'h0007, 3, 1'b0);
    checkOutput("midframe_q", 16'(q), 16'(expQ(8'h15)));
    rst = 1'b1;
    #1;
    checkOutput("async_rst_q", 16'(q), 16'(expQ(8'h00)));
    checkOutput("async_rst_done", 16'(done), 16'h0);
    checkOutput("async_rst_state", 16'(dut.state_q), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();

    // LAST without EN must not start or finish anything.
    last = 1'b1;
    idleCycle();
    last = 1'b0;
    idleCycle();
    checkOutput("last_no_en_done", 16'(done), 16'h0);

    sendBits(16'h0001, 8, 1'b1);
    checkOutput("byte01_q", 16'(q), 16'(expQ(8'h07)));
    checkOutput("byte01_done", 16'(done), 16'h1);
    checkOutput("byte01_zero", 16'(zero), 16'h0);
    idleCycle();
    checkOutput("byte01_done_fall", 16'(done), 16'h0);
    checkOutput("byte01_q_hold", 16'(q), 16'(expQ(8'h07)));

    sendBits(16'h0080, 8, 1'b1);
    checkOutput("byte80_q", 16'(q), 16'(expQ(8'h89)));
    checkOutput("byte80_done", 16'(done), 16'h1);
    idleCycle();
    checkOutput("byte80_done_fall", 16'(done), 16'h0);

    for (int b = 8; b >= 0; b--) begin
      logic [7:0] cur;
      cur = digits[b*8 +: 8];
      sendBits(16'(cur), 8, (b == 0));
      if (b == 1) checkOutput("check_busy_done", 16'(done), 16'h0);
    end
    checkOutput("check_q", 16'(q), 16'(expQ(8'hF4)));
    checkOutput("check_done", 16'(done), 16'h1);
    idleCycle();
    checkOutput("check_done_fall", 16'(done), 16'h0);
    checkOutput("check_q_hold", 16'(q), 16'(expQ(8'hF4)));

    // Residue frame, then a new frame starting in the FIN cycle.
    sendBits(16'h0107, 16, 1'b1);
    checkOutput("residue_q", 16'(q), 16'(expQ(8'h00)));
    checkOutput("residue_zero", 16'(zero), 16'h1);
    checkOutput("residue_done", 16'(done), 16'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_first_done", 16'(done), 16'h0);
    sendBits(16'h0001, 7, 1'b1);
    checkOutput("b2b_q", 16'(q), 16'(expQ(8'h07)));
    checkOutput("b2b_done", 16'(done), 16'h1);
    idleCycle();

    // CLR beats EN&LAST: bit dropped, INIT reloaded, no DONE.
    sendBits(16'h0007, 3, 1'b0);
    checkOutput("pre_clr_q", 16'(q), 16'(expQ(8'h15)));
    clr = 1'b1;
    applyStimulus(1'b1, 1'b1);
    clr = 1'b0;
    checkOutput("clr_q", 16'(q), 16'(expQ(8'h00)));
    checkOutput("clr_done", 16'(done), 16'h0);
    idleCycle();
    checkOutput("clr_done_after", 16'(done), 16'h0);
    sendBits(16'h0001, 8, 1'b1);
    checkOutput("post_clr_q", 16'(q), 16'(expQ(8'h07)));
    checkOutput("post_clr_zero", 16'(zero), 16'h0);
    checkOutput("post_clr_done", 16'(done), 16'h1);
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
